mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between a CPU and a host loader.
// Define MEM_ARB_TIMEOUT_EN to abort accesses that see no mem_ack within TIMEOUT cycles.
module mem_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_re,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_adr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_stall,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [WIDTH-1:0] host_adr,
  input  logic [WIDTH-1:0] host_wdata,
  output logic [WIDTH-1:0] host_rdata,
  output logic             host_ack,
  output logic             mem_re,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             grant_host,
  output logic             timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_CPU, S_HOST} state_t;

  typedef struct packed {
    logic             we;
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] wdata;
  } acc_t;

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("mem_arbiter: TIMEOUT must be at least 1");
  end

  state_t           state_q, state_d;
  acc_t             acc_q, acc_d;
  logic             last_host;
  logic             cpu_done;
  logic             cpu_pend, host_pend;
  logic             busy, expire, fin;
  logic [WIDTH-1:0] rdata_fin;

  // A requester whose done/ack is showing this cycle is not re-granted.
  assign cpu_pend  = (cpu_re | cpu_we) & ~cpu_done;
  assign host_pend = host_req & ~host_ack;
  assign busy      = (state_q != S_IDLE);
  assign fin       = busy & (mem_ack | expire);
  assign rdata_fin = mem_ack ? mem_rdata : '1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_pend && (!host_pend || last_host)) begin
          state_d = S_CPU;
          acc_d   = '{we: cpu_we, adr: cpu_adr, wdata: cpu_wdata};
        end else if (host_pend) begin
          state_d = S_HOST;
          acc_d   = '{we: host_we, adr: host_adr, wdata: host_wdata};
        end
      end
      S_CPU, S_HOST: begin
        if (fin) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      last_host  <= 1'b1;
      cpu_done   <= 1'b0;
      host_ack   <= 1'b0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cpu_done <= fin & (state_q == S_CPU);
      host_ack <= fin & (state_q == S_HOST);
      if (fin) begin
        last_host <= (state_q == S_HOST);
        if (!acc_q.we && state_q == S_CPU)  cpu_rdata  <= rdata_fin;
        if (!acc_q.we && state_q == S_HOST) host_rdata <= rdata_fin;
      end
    end
  end

  // Gated with rst_n so the port is quiet for the whole reset, not just after the first edge.
  assign mem_re     = rst_n & busy & ~acc_q.we;
  assign mem_we     = rst_n & busy & acc_q.we;
  assign grant_host = rst_n & (state_q == S_HOST);
  assign mem_adr    = acc_q.adr;
  assign mem_wdata  = acc_q.wdata;
  assign cpu_stall  = (cpu_re | cpu_we) & ~cpu_done;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;
  logic          tmo_q;

  // Fires in the TIMEOUT-th busy cycle without an ack; mem_ack wins a tie.
  assign expire = busy & ~mem_ack & (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      tmo_q    <= 1'b0;
    end else begin
      if (!busy || fin) wait_cnt <= '0;
      else              wait_cnt <= wait_cnt + CW'(1);
      if (expire) tmo_q <= 1'b1;
    end
  end

  assign timeout_err = rst_n & tmo_q;
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed checks of the arbiter's key scenarios plus a randomized run against a transaction-level model.
module tb_mem_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_re = 1'b0, cpu_we = 1'b0;
  logic [W-1:0] cpu_adr = '0, cpu_wdata = '0;
  logic [W-1:0] cpu_rdata;
  logic         cpu_stall;
  logic         host_req = 1'b0, host_we = 1'b0;
  logic [W-1:0] host_adr = '0, host_wdata = '0;
  logic [W-1:0] host_rdata;
  logic         host_ack;
  logic         mem_re, mem_we;
  logic [W-1:0] mem_adr, mem_wdata;
  logic [W-1:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic         grant_host, timeout_err;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(W), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_adr(host_adr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack),
    .mem_re(mem_re), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .grant_host(grant_host), .timeout_err(timeout_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {timeout_err, cpu_stall, host_ack, grant_host, mem_we, mem_re}
  function automatic logic [5:0] ctrl();
    return {timeout_err, cpu_stall, host_ack, grant_host, mem_we, mem_re};
  endfunction

  task automatic idle_in();
    cpu_re = 1'b0; cpu_we = 1'b0; host_req = 1'b0; host_we = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_in();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: one outstanding transaction plus a word-addressed memory image.
  logic [W-1:0] mem_arr [256];
  int           m_own, m_age, m_lat;
  logic [W-1:0] m_adr, m_wd, m_crd, m_hrd;
  logic         m_we, m_lh, m_cdone, m_hack, n_cd, n_ha, cp, hp, ack;
  bit           cpu_act, host_act, cpu_ret, host_ret;
  int           n, k;
  logic [3:0]   seq;

  initial begin
    // reset state, with requests present
    rst_n = 1'b0; cpu_re = 1'b1; host_req = 1'b1; host_we = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ctrl", ctrl(), 6'b010000);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_host_rdata", host_rdata, 0);
    idle_in(); #1;
    chk("rst_stall_off", cpu_stall, 0);
    @(negedge clk); rst_n = 1'b1;

    // CPU read, ack in first CPU cycle
    cpu_re = 1'b1; cpu_adr = 8'h12; #1;
    chk("c30_idle", ctrl(), 6'b010000);
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 8'hA5; #1;
    chk("c30_busy", ctrl(), 6'b010001);
    chk("c30_adr", mem_adr, 8'h12);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk("c30_done", ctrl(), 6'b000000);
    chk("c30_rdata", cpu_rdata, 8'hA5);
    @(negedge clk); cpu_re = 1'b0; #1;
    chk("c30_quiet", ctrl(), 6'b000000);

    // both held: last served was CPU, so host, CPU, host, CPU
    cpu_re = 1'b1; cpu_adr = 8'h40; host_req = 1'b1; host_we = 1'b0; host_adr = 8'h50;
    n = 0; seq = '0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      @(negedge clk); #1;
      if (mem_re | mem_we) begin
        seq[n] = grant_host;
        n++;
        mem_ack = 1'b1;
        mem_rdata = 8'(8'hC0 + n);
        if (n == 4) host_req = 1'b0;
      end else begin
        mem_ack = 1'b0;
      end
    end
    chk("alt_count", n, 4);
    chk("alt_seq", seq, 4'b0101);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk("alt_done", ctrl(), 6'b000000);
    chk("alt_cpu_rdata", cpu_rdata, 8'hC4);
    chk("alt_host_rdata", host_rdata, 8'hC3);
    cpu_re = 1'b0;

    // host write, ack after 3 busy cycles
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_adr = 8'h3C; host_wdata = 8'h7E; #1;
    chk("h31_idle", ctrl(), 6'b000000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ack = (i == 2); #1;
      chk("h31_busy", ctrl(), 6'b000110);
      chk("h31_adr", mem_adr, 8'h3C);
      chk("h31_wdata", mem_wdata, 8'h7E);
    end
    @(negedge clk); mem_ack = 1'b0; #1;
    chk("h31_ack", ctrl(), 6'b001000);
    chk("h31_host_rdata", host_rdata, 8'hC3);
    host_req = 1'b0;
    @(negedge clk); #1;
    chk("h31_once", ctrl(), 6'b000000);

    // reset in the second cycle of a host access
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_adr = 8'h11; host_wdata = 8'h22;
    @(negedge clk); #1;
    chk("r33_first", ctrl(), 6'b000110);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("r33_in_rst", ctrl(), 6'b000000);
    @(negedge clk); rst_n = 1'b1; host_req = 1'b0; #1;
    chk("r33_after", ctrl(), 6'b000000);
    chk("r33_host_rdata", host_rdata, 0);
    chk("r33_cpu_rdata", cpu_rdata, 0);
    @(negedge clk); #1;
    chk("r33_noack", ctrl(), 6'b000000);

    // randomized run against the model
    do_reset();
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'($urandom);
    m_own = 0; m_age = 0; m_lat = 0; m_lh = 1'b1; m_cdone = 1'b0; m_hack = 1'b0;
    m_crd = '0; m_hrd = '0; m_adr = '0; m_wd = '0; m_we = 1'b0;
    cpu_act = 0; host_act = 0; cpu_ret = 0; host_ret = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cpu_ret) cpu_act = 0;
      if (host_ret) host_act = 0;
      if (!cpu_act && $urandom_range(0, 1) == 1) begin
        cpu_act = 1;
        k = int'($urandom_range(0, 2));
        cpu_re = (k != 1); cpu_we = (k != 0);
        cpu_adr = 8'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
      end
      if (!cpu_act) begin cpu_re = 1'b0; cpu_we = 1'b0; end
      if (!host_act && $urandom_range(0, 2) == 0) begin
        host_act = 1;
        host_we = 1'($urandom_range(0, 1));
        host_adr = 8'($urandom_range(0, 15)); host_wdata = 8'($urandom);
      end
      host_req = host_act;
      if (m_own != 0) begin
        ack = (m_age >= m_lat);
        mem_rdata = ack ? mem_arr[m_adr] : 8'($urandom);
      end else begin
        ack = ($urandom_range(0, 3) == 0);
        mem_rdata = 8'($urandom);
      end
      mem_ack = ack;
      #1;
      chk("rnd_ctrl", ctrl(), {1'b0, (cpu_re | cpu_we) & ~m_cdone, m_hack, m_own == 2,
                               m_own != 0 && m_we, m_own != 0 && !m_we});
      if (m_own != 0) begin
        chk("rnd_adr", mem_adr, m_adr);
        if (m_we) chk("rnd_wdata", mem_wdata, m_wd);
      end
      chk("rnd_cpu_rdata", cpu_rdata, m_crd);
      chk("rnd_host_rdata", host_rdata, m_hrd);
      cpu_ret = m_cdone; host_ret = m_hack;
      n_cd = 1'b0; n_ha = 1'b0;
      if (m_own != 0) begin
        if (ack) begin
          if (m_we)            mem_arr[m_adr] = m_wd;
          else if (m_own == 1) m_crd = mem_arr[m_adr];
          else                 m_hrd = mem_arr[m_adr];
          m_lh = (m_own == 2);
          if (m_own == 1) n_cd = 1'b1; else n_ha = 1'b1;
          m_own = 0;
        end else begin
          m_age++;
        end
      end else begin
        cp = (cpu_re | cpu_we) && !m_cdone;
        hp = host_req && !m_hack;
        if (cp && (!hp || m_lh)) begin
          m_own = 1; m_we = cpu_we; m_adr = cpu_adr; m_wd = cpu_wdata;
        end else if (hp) begin
          m_own = 2; m_we = host_we; m_adr = host_adr; m_wd = host_wdata;
        end
        if (m_own != 0) begin m_age = 0; m_lat = int'($urandom_range(0, 4)); end
      end
      m_cdone = n_cd; m_hack = n_ha;
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // CPU read never acked
    do_reset();
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_adr = 8'h22; mem_ack = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk); #1;
      if (mem_re) n++;
      else if (n > 0) break;
    end
    chk("tmo_cycles", n, 15);
    chk("tmo_stall", cpu_stall, 0);
    chk("tmo_rdata", cpu_rdata, 8'hFF);
    chk("tmo_err", timeout_err, 1);
    cpu_re = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("tmo_sticky", timeout_err, 1);
    do_reset();
    #1;
    chk("tmo_cleared", timeout_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
